param_regfile: RTL and testbench



---
 rtl/param_regfile.sv | 93 +++++++++
 tb/tb_param_regfile.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_regfile.sv
// Parametrised register file: DEPTH x WIDTH storage, NUM_READ read ports, one write port.
// Optional hardwired zero register, write-to-read bypass and registered read data.
module param_regfile #(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned NUM_READ = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned READ_LAT = 0,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [AW-1:0]             wr_addr,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic [NUM_READ*AW-1:0]    rd_addr,
  output logic [NUM_READ*WIDTH-1:0] rd_data,
  output logic                      wr_err
);

  localparam int unsigned ZADDR = DEPTH - 1;

  logic [WIDTH-1:0]          mem [DEPTH];
  logic                      wr_in_range;
  logic                      wr_hits_zero;
  logic                      wr_ok;
  logic                      wr_drop;
  logic [NUM_READ*WIDTH-1:0] rd_comb;

  // Classify the write: committed, or dropped and flagged next cycle.
  always_comb begin
    wr_in_range  = 32'(wr_addr) < DEPTH;
    wr_hits_zero = (ZERO_REG != 0) && (32'(wr_addr) == ZADDR);
    wr_ok        = wr_en && wr_in_range && !wr_hits_zero;
    wr_drop      = wr_en && !wr_ok;
  end

  // Storage and error flag; reset wins over a coincident write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
      wr_err <= 1'b0;
    end else begin
      if (wr_ok) begin
        mem[wr_addr] <= wr_data;
      end
      wr_err <= wr_drop;
    end
  end

  for (genvar p = 0; p < int'(NUM_READ); p++) begin : g_rd
    logic [AW-1:0]    ra;
    logic [WIDTH-1:0] rv;

    assign ra = rd_addr[p*AW +: AW];

    // Read priority: out of range, zero register, bypass, storage.
    always_comb begin
      rv = '0;
      if (32'(ra) >= DEPTH) begin
        rv = '0;
      end else if ((ZERO_REG != 0) && (32'(ra) == ZADDR)) begin
        rv = '0;
      end else if ((BYPASS != 0) && wr_ok && (wr_addr == ra)) begin
        rv = wr_data;
      end else begin
        rv = mem[ra];
      end
    end

    assign rd_comb[p*WIDTH +: WIDTH] = rv;
  end

  if (READ_LAT != 0) begin : g_lat
    logic [NUM_READ*WIDTH-1:0] rd_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        rd_q <= '0;
      end else begin
        rd_q <= rd_comb;
      end
    end

    assign rd_data = rd_q;
  end else begin : g_comb
    assign rd_data = rd_comb;
  end

endmodule

// File: tb/tb_param_regfile.sv
// Bench for param_regfile: five configurations share one stimulus stream and are
// compared against an array-based reference model built from the read/write rules.
module tb_param_regfile;

  localparam int NK = 5;
  localparam int DEP [NK] = '{32, 32, 20, 32, 20};
  localparam int ZR  [NK] = '{1, 0, 1, 1, 0};
  localparam int BP  [NK] = '{1, 0, 1, 1, 0};
  localparam int RL  [NK] = '{0, 0, 0, 1, 1};

  logic         clk;
  logic         reset;
  logic         wr_en;
  logic [4:0]   wr_addr;
  logic [63:0]  wr_data;
  logic [9:0]   rd_addr;
  logic [127:0] rdd  [NK];
  logic         werr [NK];

  logic [63:0]  m    [NK][32];
  logic [63:0]  pend [NK][2];
  logic         eerr [NK];
  int           checks;
  int           errors;

  param_regfile #(.WIDTH(64), .DEPTH(32), .NUM_READ(2), .ZERO_REG(1), .BYPASS(1), .READ_LAT(0)) u0 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rdd[0]), .wr_err(werr[0]));
  param_regfile #(.WIDTH(64), .DEPTH(32), .NUM_READ(2), .ZERO_REG(0), .BYPASS(0), .READ_LAT(0)) u1 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rdd[1]), .wr_err(werr[1]));
  param_regfile #(.WIDTH(64), .DEPTH(20), .NUM_READ(2), .ZERO_REG(1), .BYPASS(1), .READ_LAT(0)) u2 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rdd[2]), .wr_err(werr[2]));
  param_regfile #(.WIDTH(64), .DEPTH(32), .NUM_READ(2), .ZERO_REG(1), .BYPASS(1), .READ_LAT(1)) u3 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rdd[3]), .wr_err(werr[3]));
  param_regfile #(.WIDTH(64), .DEPTH(20), .NUM_READ(2), .ZERO_REG(0), .BYPASS(0), .READ_LAT(1)) u4 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rdd[4]), .wr_err(werr[4]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic wr_valid(int k);
    return (int'(wr_addr) < DEP[k]) && !(ZR[k] == 1 && int'(wr_addr) == DEP[k] - 1);
  endfunction

  function automatic logic [63:0] comb_rd(int k, logic [4:0] a);
    if (int'(a) >= DEP[k]) return 64'd0;
    if (ZR[k] == 1 && int'(a) == DEP[k] - 1) return 64'd0;
    if (BP[k] == 1 && wr_en && wr_addr == a && wr_valid(k)) return wr_data;
    return m[k][a];
  endfunction

  function automatic logic [63:0] exp_rd(int k, int p);
    logic [4:0] a;
    a = rd_addr[p*5 +: 5];
    return (RL[k] == 1) ? pend[k][p] : comb_rd(k, a);
  endfunction

  // Advance one clock and apply the same edge to the model.
  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < NK; k++) begin
      if (reset) begin
        for (int a = 0; a < 32; a++) m[k][a] = 64'd0;
        pend[k][0] = 64'd0;
        pend[k][1] = 64'd0;
        eerr[k]    = 1'b0;
      end else begin
        for (int p = 0; p < 2; p++) pend[k][p] = comb_rd(k, rd_addr[p*5 +: 5]);
        eerr[k] = wr_en && !wr_valid(k);
        if (wr_en && wr_valid(k)) m[k][wr_addr] = wr_data;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_en = 1'b1; wr_addr = 5'd3; wr_data = '1; rd_addr = '0;
    tick();
    reset = 1'b0; wr_en = 1'b0;
    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'(31 - a), 5'(a)};
      #3;
      for (int k = 0; k < NK; k++) begin
        for (int p = 0; p < 2; p++) begin
          checks++;
          if (rdd[k][p*64 +: 64] !== 64'd0) begin
            errors++;
            $display("FAIL reset_read dut%0d port%0d addr%0d: got %h expected 0", k, p, a, rdd[k][p*64 +: 64]);
          end
        end
        checks++;
        if (werr[k] !== 1'b0) begin
          errors++;
          $display("FAIL reset_wr_err dut%0d: got %b expected 0", k, werr[k]);
        end
      end
      tick();
    end
  endtask

  task automatic test_basic();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hDEADBEEF_00000005; rd_addr = {5'd6, 5'd6};
    tick();
    wr_en = 1'b0; rd_addr = {5'd5, 5'd5};
    #3;
    for (int p = 0; p < 2; p++) begin
      checks++;
      if (rdd[0][p*64 +: 64] !== 64'hDEADBEEF_00000005) begin
        errors++;
        $display("FAIL basic_read port%0d: got %h expected deadbeef00000005", p, rdd[0][p*64 +: 64]);
      end
    end
    tick();
    rd_addr = {5'd5, 5'd6};
    #3;
    checks++;
    if (rdd[0][63:0] !== 64'd0) begin
      errors++;
      $display("FAIL basic_addr6: got %h expected 0", rdd[0][63:0]);
    end
    checks++;
    if (rdd[3][63:0] !== 64'hDEADBEEF_00000005) begin
      errors++;
      $display("FAIL basic_lat1: got %h expected deadbeef00000005", rdd[3][63:0]);
    end
    tick();
  endtask

  task automatic test_zero_reg();
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = '1; rd_addr = {5'd31, 5'd31};
    #3;
    checks++;
    if (rdd[0][63:0] !== 64'd0) begin
      errors++;
      $display("FAIL zero_no_bypass: got %h expected 0", rdd[0][63:0]);
    end
    tick();
    wr_en = 1'b0;
    #3;
    checks++;
    if (rdd[0][63:0] !== 64'd0) begin
      errors++;
      $display("FAIL zero_read: got %h expected 0", rdd[0][63:0]);
    end
    checks++;
    if (werr[0] !== 1'b1) begin
      errors++;
      $display("FAIL zero_wr_err: got %b expected 1", werr[0]);
    end
    checks++;
    if (rdd[1][63:0] !== 64'hFFFFFFFF_FFFFFFFF) begin
      errors++;
      $display("FAIL nozero_read: got %h expected ffffffffffffffff", rdd[1][63:0]);
    end
    checks++;
    if (werr[1] !== 1'b0) begin
      errors++;
      $display("FAIL nozero_wr_err: got %b expected 0", werr[1]);
    end
    tick();
    #3;
    checks++;
    if (werr[0] !== 1'b0) begin
      errors++;
      $display("FAIL zero_wr_err_clear: got %b expected 0", werr[0]);
    end
    tick();
  endtask

  task automatic test_bypass();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'h11; rd_addr = '0;
    tick();
    wr_data = 64'h22; rd_addr = {5'd0, 5'd7};
    #3;
    checks++;
    if (rdd[0][63:0] !== 64'h22) begin
      errors++;
      $display("FAIL bypass_on: got %h expected 22", rdd[0][63:0]);
    end
    checks++;
    if (rdd[1][63:0] !== 64'h11) begin
      errors++;
      $display("FAIL bypass_off_old: got %h expected 11", rdd[1][63:0]);
    end
    tick();
    wr_en = 1'b0;
    #3;
    checks++;
    if (rdd[1][63:0] !== 64'h22) begin
      errors++;
      $display("FAIL bypass_off_new: got %h expected 22", rdd[1][63:0]);
    end
    checks++;
    if (rdd[3][63:0] !== 64'h22) begin
      errors++;
      $display("FAIL bypass_lat1: got %h expected 22", rdd[3][63:0]);
    end
    tick();
  endtask

  task automatic test_out_of_range();
    wr_en = 1'b1; wr_addr = 5'd25; wr_data = 64'hAB; rd_addr = {5'd25, 5'd25};
    #3;
    checks++;
    if (rdd[2][63:0] !== 64'd0) begin
      errors++;
      $display("FAIL oor_no_bypass: got %h expected 0", rdd[2][63:0]);
    end
    tick();
    wr_en = 1'b0;
    #3;
    checks++;
    if (werr[2] !== 1'b1) begin
      errors++;
      $display("FAIL oor_wr_err: got %b expected 1", werr[2]);
    end
    checks++;
    if (rdd[2][63:0] !== 64'd0) begin
      errors++;
      $display("FAIL oor_read: got %h expected 0", rdd[2][63:0]);
    end
    checks++;
    if (rdd[0][63:0] !== 64'hAB || werr[0] !== 1'b0) begin
      errors++;
      $display("FAIL inrange_d32: got %h/%b expected ab/0", rdd[0][63:0], werr[0]);
    end
    tick();
    for (int a = 0; a < 20; a++) begin
      rd_addr = {5'(a), 5'(a)};
      #3;
      checks++;
      if (rdd[2][63:0] !== m[2][a]) begin
        errors++;
        $display("FAIL oor_storage addr%0d: got %h expected %h", a, rdd[2][63:0], m[2][a]);
      end
      tick();
    end
  endtask

  task automatic test_readlat();
    wr_en = 1'b1; wr_addr = 5'd2; wr_data = 64'h33; rd_addr = '0;
    tick();
    wr_en = 1'b0; rd_addr = {5'd2, 5'd2};
    tick();
    reset = 1'b1; wr_en = 1'b1; wr_data = 64'h44;
    #3;
    for (int p = 0; p < 2; p++) begin
      checks++;
      if (rdd[3][p*64 +: 64] !== 64'h33) begin
        errors++;
        $display("FAIL lat1_read port%0d: got %h expected 33", p, rdd[3][p*64 +: 64]);
      end
    end
    tick();
    reset = 1'b0; wr_en = 1'b0;
    #3;
    checks++;
    if (rdd[3][63:0] !== 64'd0) begin
      errors++;
      $display("FAIL lat1_reset_out: got %h expected 0", rdd[3][63:0]);
    end
    tick();
    #3;
    checks++;
    if (rdd[3][63:0] !== 64'd0 || rdd[0][63:0] !== 64'd0) begin
      errors++;
      $display("FAIL reset_beats_write: got %h/%h expected 0/0", rdd[3][63:0], rdd[0][63:0]);
    end
    tick();
  endtask

  task automatic test_random();
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [63:0] exp;
    for (int c = 0; c < 600; c++) begin
      reset   = ($urandom_range(0, 39) == 0);
      wr_en   = ($urandom_range(0, 2) != 0);
      wr_addr = 5'($urandom_range(0, 31));
      wr_data = {$urandom, $urandom};
      ra0     = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      ra1     = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      rd_addr = {ra1, ra0};
      #3;
      for (int k = 0; k < NK; k++) begin
        for (int p = 0; p < 2; p++) begin
          exp = exp_rd(k, p);
          checks++;
          if (rdd[k][p*64 +: 64] !== exp) begin
            errors++;
            $display("FAIL rand_read cyc%0d dut%0d port%0d: got %h expected %h", c, k, p, rdd[k][p*64 +: 64], exp);
          end
        end
        checks++;
        if (werr[k] !== eerr[k]) begin
          errors++;
          $display("FAIL rand_wr_err cyc%0d dut%0d: got %b expected %b", c, k, werr[k], eerr[k]);
        end
      end
      tick();
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    test_reset();
    test_basic();
    test_zero_reg();
    test_bypass();
    test_out_of_range();
    test_readlat();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
